xnor3_vector_checker: RTL and testbench

//  Self-running stimulus/checker stage wrapped around the 3-input XNOR block.
//  It drives A,B,C through all 8 combinations, holding each for HOLD_CYCLES clocks.
//  It samples the block's output f against the reference ~(A^B^C) and accumulates a per-vector fail map.
//  It replaces hand-timed stimulus with a clocked, synthesizable board-level self-test.

---
 rtl/xnor_lab_pkg.sv | 16 +
 rtl/xnor3_vector_checker_if.sv | 25 ++
 rtl/xnor3_ref_model.sv | 11 +
 rtl/xnor3_vector_checker.sv | 111 +++++++++++
 tb/tb_xnor3_vector_checker.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/xnor_lab_pkg.sv
// rtl/xnor_lab_pkg.sv - shared state encodings and XNOR reference function for the lab checkers
package xnor_lab_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int N_VECTORS = 8;

    function automatic logic xnor3_exp(input logic a, input logic b, input logic c);
        return ~(a ^ b ^ c);
    endfunction

endpackage

// File: rtl/xnor3_vector_checker_if.sv
// rtl/xnor3_vector_checker_if.sv - stimulus, observed output and result bundle of the XNOR self-test
interface xnor3_vector_checker_if;

    logic       start;
    logic       f;
    logic       A;
    logic       B;
    logic       C;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;

    modport master (
        output start, f,
        input  A, B, C, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, f,
        output A, B, C, busy, done, pass, err_count, fail_vec
    );

endinterface

// File: rtl/xnor3_ref_model.sv
// rtl/xnor3_ref_model.sv - combinational golden model, vector index to expected XNOR output
module xnor3_ref_model
    import xnor_lab_pkg::*;
(
    input  logic [2:0] vec,
    output logic       expected
);

    assign expected = xnor3_exp(vec[2], vec[1], vec[0]);

endmodule

// File: rtl/xnor3_vector_checker.sv
// rtl/xnor3_vector_checker.sv - sweeps A,B,C through all 8 vectors and records which ones the XNOR block got wrong
module xnor3_vector_checker
    import xnor_lab_pkg::*;
#(
    parameter int HOLD_CYCLES = 100,
    parameter int CNT_W       = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    xnor3_vector_checker_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAST_HOLD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]       LAST_VEC  = 3'(N_VECTORS - 1);

    state_t           state, state_nxt;
    logic [2:0]       vec, vec_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [3:0]       err_count, err_count_nxt;
    logic [7:0]       fail_vec, fail_vec_nxt;
    logic [2:0]       abc, abc_nxt;
    logic             busy, busy_nxt;
    logic             done, done_nxt;
    logic             pass, pass_nxt;
    logic             expected;
    logic             accept;

    xnor3_ref_model u_ref (
        .vec      (vec),
        .expected (expected)
    );

    always_comb begin
        state_nxt     = state;
        vec_nxt       = vec;
        hold_cnt_nxt  = hold_cnt;
        err_count_nxt = err_count;
        fail_vec_nxt  = fail_vec;
        accept        = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    accept        = 1'b1;
                    state_nxt     = ST_DRIVE;
                    vec_nxt       = 3'd0;
                    hold_cnt_nxt  = '0;
                    err_count_nxt = 4'd0;
                    fail_vec_nxt  = 8'h00;
                end
            end
            ST_DRIVE: begin
                hold_cnt_nxt = hold_cnt + 1'b1;
                if (hold_cnt == LAST_HOLD) begin
                    hold_cnt_nxt = '0;
                    if (bus.f != expected) begin
                        fail_vec_nxt[vec] = 1'b1;
                        err_count_nxt     = err_count + 4'd1;
                    end
                    if (vec == LAST_VEC) begin
                        state_nxt = ST_DONE;
                    end else begin
                        vec_nxt = vec + 3'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Output registers trail the state by one clock, so a vector reaches A,B,C
        // one cycle after vec moves and the DUT gets HOLD_CYCLES-1 clocks to settle.
        busy_nxt = (state == ST_DRIVE);
        done_nxt = (state == ST_DONE) && !accept;
        pass_nxt = done_nxt && (err_count == 4'd0);
        abc_nxt  = (state == ST_DRIVE) ? vec : 3'b000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            vec       <= 3'd0;
            hold_cnt  <= '0;
            err_count <= 4'd0;
            fail_vec  <= 8'h00;
            abc       <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            vec       <= vec_nxt;
            hold_cnt  <= hold_cnt_nxt;
            err_count <= err_count_nxt;
            fail_vec  <= fail_vec_nxt;
            abc       <= abc_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
        end
    end

    assign bus.A         = abc[2];
    assign bus.B         = abc[1];
    assign bus.C         = abc[0];
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;
    assign bus.err_count = err_count;
    assign bus.fail_vec  = fail_vec;

endmodule

// File: tb/tb_xnor3_vector_checker.sv
// tb/tb_xnor3_vector_checker.sv - scoreboard bench for the XNOR vector self-test
module tb_xnor3_vector_checker;

    localparam int HOLD  = 4;
    localparam int CNT_W = 3;
    localparam int LAT   = 8 * HOLD + 1;

    typedef struct {
        logic [7:0] fv;
        logic [3:0] ec;
        logic       ps;
        int         sc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         sweeps_seen = 0;
    int         issued = 0;
    int         f_mode = 0;
    logic [7:0] f_mask = 8'h00;
    exp_t       sb[$];

    xnor3_vector_checker_if bus ();

    xnor3_vector_checker #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behaviour of the block under test: 0 correct, 1 stuck 0, 2 stuck 1, 3 inverted, 4 faulted where mask set
    function automatic logic good_of(input logic [2:0] idx);
        return ($countones(idx) % 2) == 0;
    endfunction

    function automatic logic f_model(input int mode, input logic [7:0] mask, input logic [2:0] idx);
        case (mode)
            0:       return good_of(idx);
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return !good_of(idx);
            default: return good_of(idx) ^ mask[idx];
        endcase
    endfunction

    assign bus.f = f_model(f_mode, f_mask, {bus.A, bus.B, bus.C});

    function automatic exp_t predict(input int mode, input logic [7:0] mask);
        exp_t e;
        e.fv = 8'h00;
        e.ec = 4'd0;
        e.sc = 0;
        for (int i = 0; i < 8; i++) begin
            if (f_model(mode, mask, 3'(i)) != good_of(3'(i))) begin
                e.fv[i] = 1'b1;
                e.ec    = e.ec + 4'd1;
            end
        end
        e.ps = (e.ec == 4'd0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    logic done_d = 1'b0;
    int   busy_len = 0;
    exp_t me;

    always @(negedge clk) begin
        if (rst) begin
            done_d   <= 1'b0;
            busy_len <= 0;
        end else begin
            done_d <= bus.done;
            if (bus.busy) busy_len <= busy_len + 1;
            if (bus.done && !done_d) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    me = sb.pop_front();
                    check("fail_vec",  32'(bus.fail_vec), 32'(me.fv));
                    check("err_count", 32'(bus.err_count), 32'(me.ec));
                    check("pass",      32'(bus.pass), 32'(me.ps));
                    check("latency",   32'(cyc - me.sc), 32'(LAT));
                    check("busy_len",  32'(busy_len), 32'(8 * HOLD));
                    check("done_abc",  32'({bus.A, bus.B, bus.C, bus.busy}), 32'd0);
                end
                busy_len    <= 0;
                sweeps_seen <= sweeps_seen + 1;
            end
        end
    end

    task automatic pulse_start(output int sc);
        @(negedge clk);
        bus.start = 1'b1;
        sc = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_sweep(input int target);
        int n = 0;
        while (sweeps_seen < target && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(sweeps_seen >= target), 32'd1);
        @(negedge clk);
    endtask

    task automatic run_sweep(input int mode, input logic [7:0] mask, input bit use_ref,
                             input logic [7:0] fv_ref, input logic [3:0] ec_ref, input int restart_at);
        exp_t e;
        int   sc;
        int   dummy;
        @(negedge clk);
        f_mode = mode;
        f_mask = mask;
        e = predict(mode, mask);
        if (use_ref) begin
            e.fv = fv_ref;
            e.ec = ec_ref;
            e.ps = (ec_ref == 4'd0);
        end
        pulse_start(sc);
        e.sc = sc;
        sb.push_back(e);
        issued++;
        check("start_clears", 32'({bus.done, bus.pass, bus.err_count, bus.fail_vec}), 32'd0);
        @(negedge clk);
        check("first_cycle", 32'({bus.busy, bus.A, bus.B, bus.C}), 32'b1000);
        if (restart_at > 0) begin
            repeat (restart_at) @(negedge clk);
            pulse_start(dummy);
        end
        wait_sweep(issued);
    endtask

    task automatic abort_test();
        int sc;
        @(negedge clk);
        f_mode = 3;
        pulse_start(sc);
        repeat (4 * HOLD + 1) @(negedge clk);
        check("abort_abc_at_vec4", 32'({bus.A, bus.B, bus.C}), 32'd4);
        check("abort_partial", 32'({bus.err_count, bus.fail_vec}), 32'({4'd4, 8'h0F}));
        #2 rst = 1'b1;
        #1;
        check("abort_outputs", 32'({bus.A, bus.B, bus.C, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_vec}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        @(negedge clk);
        check("reset_outputs", 32'({bus.A, bus.B, bus.C, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_vec}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_quiet", 32'({bus.busy, bus.done, bus.pass}), 32'd0);

        run_sweep(0, 8'h00, 1'b1, 8'h00, 4'd0, 0);
        run_sweep(1, 8'h00, 1'b1, 8'h69, 4'd4, 0);
        run_sweep(2, 8'h00, 1'b1, 8'h96, 4'd4, 0);
        run_sweep(3, 8'h00, 1'b1, 8'hFF, 4'd8, 0);
        repeat (5) @(negedge clk);
        check("done_held", 32'({bus.done, bus.err_count, bus.fail_vec}), 32'({1'b1, 4'd8, 8'hFF}));

        for (int k = 0; k < 6; k++) begin
            run_sweep(int'($urandom_range(0, 4)), 8'($urandom), 1'b0, 8'h00, 4'd0, 0);
        end

        abort_test();
        run_sweep(0, 8'h00, 1'b1, 8'h00, 4'd0, 0);

        run_sweep(4, 8'($urandom), 1'b0, 8'h00, 4'd0, 2 * HOLD);
        run_sweep(2, 8'h00, 1'b1, 8'h96, 4'd4, 0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
